// File: rtl/phv_assembler.sv
// phv_assembler: pairs buffered PHV remainders with ALU results into full PHVs
module phv_assembler_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          full, wr;
  assign full = cnt == CW'(DEPTH);
  assign wr   = push && (!full || pop);
  assign ovf  = push && full && !pop;
  assign dout = mem[rp];
  // storage is not reset; only accepted pushes write it
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
endmodule

module phv_assembler #(
  parameter int PHV_LEN    = 1124,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [355:0]       remain_in,
  input  logic               remain_in_valid,
  input  logic [383:0]       alu_out_6B,
  input  logic [255:0]       alu_out_4B,
  input  logic [127:0]       alu_out_2B,
  input  logic               alu_out_valid,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_out_valid,
  input  logic               phv_out_ready,
  output logic               stall_out,
  output logic               err_overflow,
  output logic               err_orphan,
  output logic [31:0]        phv_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0]  rem_cnt, res_cnt;
  logic [355:0]   rem_head;
  logic [767:0]   res_head;
  logic           rem_ovf, res_ovf, out_free, pair_pop, xfer;
  assign out_free  = !phv_out_valid || phv_out_ready;
  assign pair_pop  = rem_cnt != '0 && res_cnt != '0 && out_free;
  assign xfer      = phv_out_valid && phv_out_ready;
  assign stall_out = rem_cnt >= CW'(FIFO_DEPTH - 1) || res_cnt >= CW'(FIFO_DEPTH - 1);
  phv_assembler_fifo #(.W(356), .DEPTH(FIFO_DEPTH)) rem_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (remain_in_valid),
    .pop  (pair_pop),
    .din  (remain_in),
    .dout (rem_head),
    .cnt  (rem_cnt),
    .ovf  (rem_ovf)
  );
  phv_assembler_fifo #(.W(768), .DEPTH(FIFO_DEPTH)) res_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (alu_out_valid),
    .pop  (pair_pop),
    .din  ({alu_out_6B, alu_out_4B, alu_out_2B}),
    .dout (res_head),
    .cnt  (res_cnt),
    .ovf  (res_ovf)
  );
  // output register: load a fresh pair when free, otherwise drop valid after a transfer
  always_ff @(posedge clk)
    if (rst) begin
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
    end else if (pair_pop) begin
      phv_out       <= PHV_LEN'({res_head, rem_head});
      phv_out_valid <= 1'b1;
    end else if (xfer) begin
      phv_out_valid <= 1'b0;
    end
  // sticky error flags and wrapping transfer counter
  always_ff @(posedge clk)
    if (rst) begin
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
      phv_cnt      <= '0;
    end else begin
      err_overflow <= err_overflow | rem_ovf | res_ovf;
      err_orphan   <= err_orphan | (alu_out_valid && rem_cnt == '0 && !remain_in_valid);
      phv_cnt      <= phv_cnt + 32'(xfer);
    end
endmodule

// File: tb/tb_phv_assembler.sv
// tb_phv_assembler: scoreboard bench pairing remainder/result streams into expected PHVs
module tb_phv_assembler;
  logic          clk = 0;
  logic          rst = 1;
  logic [355:0]  remain_in = '0;
  logic          remain_in_valid = 0;
  logic [383:0]  alu_out_6B = '0;
  logic [255:0]  alu_out_4B = '0;
  logic [127:0]  alu_out_2B = '0;
  logic          alu_out_valid = 0;
  logic [1123:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready = 0;
  logic          stall_out, err_overflow, err_orphan;
  logic [31:0]   phv_cnt;

  phv_assembler dut (
    .clk             (clk),
    .rst             (rst),
    .remain_in       (remain_in),
    .remain_in_valid (remain_in_valid),
    .alu_out_6B      (alu_out_6B),
    .alu_out_4B      (alu_out_4B),
    .alu_out_2B      (alu_out_2B),
    .alu_out_valid   (alu_out_valid),
    .phv_out         (phv_out),
    .phv_out_valid   (phv_out_valid),
    .phv_out_ready   (phv_out_ready),
    .stall_out       (stall_out),
    .err_overflow    (err_overflow),
    .err_orphan      (err_orphan),
    .phv_cnt         (phv_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [355:0]  rem_q [$];
  logic [767:0]  res_q [$];
  logic [1123:0] exp_q [$];
  logic [31:0]   n_xfer = '0;
  logic [1123:0] mon_e;

  task automatic chk(input string n, input logic [383:0] act, input logic [383:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, want);
    end
  endtask

  task automatic cmp_phv(input string n, input logic [1123:0] e);
    chk({n, "_6b"}, phv_out[1123:740], e[1123:740]);
    chk({n, "_4b"}, 384'(phv_out[739:484]), 384'(e[739:484]));
    chk({n, "_2b"}, 384'(phv_out[483:356]), 384'(e[483:356]));
    chk({n, "_rem"}, 384'(phv_out[355:0]), 384'(e[355:0]));
  endtask

  function automatic logic [355:0] rrem();
    logic [355:0] r = '0;
    for (int i = 0; i < 12; i++) r = {r[323:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [767:0] rres();
    logic [767:0] r = '0;
    for (int i = 0; i < 24; i++) r = {r[735:0], 32'($urandom())};
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [355:0] rd, input logic av,
                       input logic [767:0] ad, input logic track);
    logic [355:0] r;
    logic [767:0] a;
    remain_in_valid = rv;
    remain_in = rd;
    alu_out_valid = av;
    {alu_out_6B, alu_out_4B, alu_out_2B} = ad;
    if (track) begin
      if (rv) rem_q.push_back(rd);
      if (av) res_q.push_back(ad);
      while (rem_q.size() > 0 && res_q.size() > 0) begin
        r = rem_q.pop_front();
        a = res_q.pop_front();
        exp_q.push_back({a, r});
      end
    end
    step;
    remain_in_valid = 0;
    alu_out_valid = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    remain_in_valid = 1;
    alu_out_valid = 1;
    step;
    rst = 0;
    remain_in_valid = 0;
    alu_out_valid = 0;
    rem_q.delete();
    res_q.delete();
    exp_q.delete();
    n_xfer = '0;
  endtask

  task automatic check_idle(input string n);
    chk({n, "_valid"}, 384'(phv_out_valid), 384'(0));
    cmp_phv({n, "_phv"}, '0);
    chk({n, "_stall"}, 384'(stall_out), 384'(0));
    chk({n, "_ovf"}, 384'(err_overflow), 384'(0));
    chk({n, "_orphan"}, 384'(err_orphan), 384'(0));
    chk({n, "_cnt"}, 384'(phv_cnt), 384'(0));
  endtask

  // monitor: every transfer must match the oldest expected PHV
  always @(negedge clk)
    if (!rst && phv_out_valid && phv_out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_phv: got a transfer, want none");
      end else begin
        mon_e = exp_q.pop_front();
        cmp_phv("phv", mon_e);
      end
      chk("mon_cnt", 384'(phv_cnt), 384'(n_xfer));
      n_xfer = n_xfer + 1;
    end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [767:0] e;
    logic rv, av;
    step;
    step;
    do_reset;
    check_idle("reset");

    // single PHV: remainder at edge 0, result at edge 2, valid only in cycle 3
    phv_out_ready = 1;
    drive(1, 356'h1, 0, '0, 1);
    step;
    e = '0;
    e[767:720] = 48'hAAAA_BBBB_CCCC;
    drive(0, '0, 1, e, 1);
    chk("lat_c2", 384'(phv_out_valid), 384'(0));
    step;
    chk("lat_c3", 384'(phv_out_valid), 384'(1));
    chk("lat_6b7", 384'(phv_out[1123:1076]), 384'(48'hAAAA_BBBB_CCCC));
    chk("lat_rem", 384'(phv_out[355:0]), 384'(1));
    step;
    chk("lat_c4", 384'(phv_out_valid), 384'(0));
    chk("lat_cnt", 384'(phv_cnt), 384'(1));

    // fill remainder FIFO, overflow it, then pair and hold with ready low
    do_reset;
    phv_out_ready = 0;
    for (int t = 0; t < 4; t++) begin
      drive(1, rrem(), 0, '0, 1);
      if (t == 1) chk("stall_2", 384'(stall_out), 384'(0));
      if (t == 2) chk("stall_3", 384'(stall_out), 384'(1));
    end
    drive(1, rrem(), 0, '0, 0);
    chk("ovf", 384'(err_overflow), 384'(1));
    for (int t = 0; t < 4; t++) drive(0, '0, 1, rres(), 1);
    for (int k = 0; k < 3; k++) begin
      chk("held_valid", 384'(phv_out_valid), 384'(1));
      cmp_phv("held", exp_q[0]);
      step;
    end
    phv_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("burst_valid", 384'(phv_out_valid), 384'(1));
    end
    step;
    chk("burst_end", 384'(phv_out_valid), 384'(0));
    chk("burst_cnt", 384'(phv_cnt), 384'(4));
    chk("burst_left", 384'(exp_q.size()), 384'(0));

    // orphan result followed by its remainder
    do_reset;
    phv_out_ready = 1;
    drive(0, '0, 1, rres(), 1);
    chk("orphan", 384'(err_orphan), 384'(1));
    chk("orphan_ovf", 384'(err_overflow), 384'(0));
    drive(1, rrem(), 0, '0, 1);
    step;
    step;
    chk("orphan_cnt", 384'(phv_cnt), 384'(1));
    chk("orphan_left", 384'(exp_q.size()), 384'(0));

    // reset with entries queued and output valid
    do_reset;
    phv_out_ready = 0;
    for (int t = 0; t < 3; t++) drive(1, rrem(), 1, rres(), 1);
    chk("pre_rst_valid", 384'(phv_out_valid), 384'(1));
    chk("pre_rst_stall", 384'(stall_out), 384'(0));
    do_reset;
    check_idle("midrst");
    phv_out_ready = 1;
    repeat (5) step;
    chk("post_rst_valid", 384'(phv_out_valid), 384'(0));
    chk("post_rst_cnt", 384'(phv_cnt), 384'(0));

    // counter wrap
    force dut.phv_cnt = 32'hFFFF_FFFF;
    step;
    release dut.phv_cnt;
    n_xfer = 32'hFFFF_FFFF;
    step;
    chk("preload", 384'(phv_cnt), 384'(32'hFFFF_FFFF));
    drive(1, rrem(), 1, rres(), 1);
    step;
    step;
    chk("wrap", 384'(phv_cnt), 384'(0));

    // random traffic with an upstream that honours stall_out
    do_reset;
    for (int c = 0; c < 400; c++) begin
      phv_out_ready = $urandom_range(0, 3) != 0;
      rv = !stall_out && $urandom_range(0, 1) == 1;
      av = !stall_out && $urandom_range(0, 1) == 1;
      drive(rv, rrem(), av, rres(), 1);
    end
    phv_out_ready = 1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) step;
    step;
    chk("rand_drain", 384'(exp_q.size()), 384'(0));
    chk("rand_ovf", 384'(err_overflow), 384'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
